// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// the stop opcode loaded on a fetch timeout, and the default timeout
// limit. Imported by fetch_timeout_ctr and fetch_unit.
package fetch_pkg;

  // Fetch sequencer states (2-bit encoding relied on by debug tooling).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_t;

  // Opcode substituted into ir when a fetch is abandoned.
  localparam logic [3:0] OPC_STOP = 4'h1;

  // Default number of unacknowledged REQ cycles before a fetch aborts.
  localparam int TIMEOUT_LIMIT_DEF = 15;

  // Address of the instruction following 'addr'; 8-bit wrap is intended.
  function automatic logic [7:0] next_pc(input logic [7:0] addr);
    return addr + 8'd1;
  endfunction

endpackage : fetch_pkg

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for a pending fetch. Cleared when a fetch is
// launched, advanced on every REQ cycle that sees no acknowledge, and
// flags terminal count on the cycle whose increment reaches LIMIT, so
// the sequencer leaves REQ after exactly LIMIT unacknowledged cycles.
// Only built when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset,   // asynchronous, active low
  input  logic i_clr,   // fetch launched this cycle
  input  logic i_en,    // REQ cycle without acknowledge
  output logic o_tc     // this cycle completes LIMIT waiting cycles
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Count unacknowledged REQ cycles; restart on every new fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: state is updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_W'(LIMIT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = i_en && (r_cnt == CNT_W'(LIMIT - 1));

endmodule : fetch_timeout_ctr

// File: rtl/fetch_unit.sv
// Instruction fetch unit. On a fetch_start pulse in IDLE it latches the
// fetch address (branch target if pc_load is also high, else pc), holds
// mem_req/mem_addr in REQ until mem_ack, then loads ir and advances pc
// during a one-cycle DONE state that pulses ir_valid.
// Build option: define FETCH_TIMEOUT_EN to abort fetches that are not
// acknowledged within TIMEOUT_LIMIT REQ cycles (ir <- stop opcode,
// sticky fetch_err). Without it REQ waits indefinitely.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_LIMIT = TIMEOUT_LIMIT_DEF
) (
  input  logic       clock,
  input  logic       reset,        // asynchronous, active low
  input  logic       fetch_start,
  input  logic       pc_load,
  input  logic [7:0] pc_din,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [7:0] ir,
  output logic [3:0] instr,
  output logic [7:0] pc,
  output logic       ir_valid,
  output logic       fetch_busy,
  output logic       fetch_err
);

  fetch_state_t r_state;
  logic [7:0]   r_pc;
  logic [7:0]   r_ir;
  logic [7:0]   r_mem_addr;
  logic         r_mem_req;
  logic         r_ir_valid;
  logic         r_busy;

  // A fetch launches only from IDLE; requests elsewhere are dropped.
  logic w_fetch_go;
  // Waiting cycle in REQ (no acknowledge this cycle).
  logic w_req_wait;
  // Fetch address: a same-cycle branch target wins over the current pc.
  logic [7:0] w_fetch_addr;
  // Timeout abort for the current REQ cycle.
  logic w_timeout;

  assign w_fetch_go   = (r_state == ST_IDLE) && fetch_start;
  assign w_req_wait   = (r_state == ST_REQ) && !mem_ack;
  assign w_fetch_addr = pc_load ? pc_din : r_pc;

`ifdef FETCH_TIMEOUT_EN
  logic r_err;

  fetch_timeout_ctr #(
    .LIMIT (TIMEOUT_LIMIT)
  ) u_timeout_ctr (
    .clock (clock),
    .reset (reset),
    .i_clr (w_fetch_go),
    .i_en  (w_req_wait),
    .o_tc  (w_timeout)
  );

  // Sticky error: set by any aborted fetch, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign fetch_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Fetch sequencer with registered outputs; pc/ir update here only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= 8'h00;
      r_ir       <= 8'h00;
      r_mem_addr <= 8'h00;
      r_mem_req  <= 1'b0;
      r_ir_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // NOTE: ir_valid defaults low each cycle and is only raised on the
      // edge entering DONE, so it is a single-cycle pulse by construction.
      r_ir_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (pc_load) begin
            r_pc <= pc_din;
          end
          if (fetch_start) begin
            r_mem_addr <= w_fetch_addr;
            r_mem_req  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            r_ir       <= mem_rdata;
            r_pc       <= next_pc(r_mem_addr);
            r_mem_req  <= 1'b0;
            r_ir_valid <= 1'b1;
            r_state    <= ST_DONE;
          end else if (w_timeout) begin
            r_ir       <= {4'h0, OPC_STOP};
            r_mem_req  <= 1'b0;
            r_ir_valid <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign ir         = r_ir;
  assign instr      = r_ir[3:0];
  assign pc         = r_pc;
  assign ir_valid   = r_ir_valid;
  assign fetch_busy = r_busy;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The driver issues fetches and
// pushes the expected (address, ir, pc) into a scoreboard queue computed
// from a simple architectural pc model; an independent monitor pops and
// compares whenever ir_valid is seen. Directed cases cover reset values,
// latency, pc wrap, branch priority, ignored inputs outside IDLE and
// reset mid-fetch, followed by randomized fetches. The timeout case is
// compiled in when FETCH_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int TB_LIMIT = 15;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] ir;
    logic [7:0] pc;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       fetch_start;
  logic       pc_load;
  logic [7:0] pc_din;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] ir;
  logic [3:0] instr;
  logic [7:0] pc;
  logic       ir_valid;
  logic       fetch_busy;
  logic       fetch_err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic [7:0] m_pc;   // architectural pc as the model sees it
  logic [7:0] m_ir;   // architectural ir as the model sees it

  fetch_unit #(.TIMEOUT_LIMIT(TB_LIMIT)) dut (
    .clock      (clock),
    .reset      (reset),
    .fetch_start(fetch_start),
    .pc_load    (pc_load),
    .pc_din     (pc_din),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ir         (ir),
    .instr      (instr),
    .pc         (pc),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ir_valid pulse must match the oldest expected fetch.
  always @(negedge clock) begin
    if (reset === 1'b1 && ir_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_ir_valid: got ir=0x%0h expected no pulse at %0t", ir, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_addr",  mem_addr, e.addr);
        check("sb_ir",    ir,       e.ir);
        check("sb_instr", instr,    e.ir[3:0]);
        check("sb_pc",    pc,       e.pc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    pc_din      = 8'h00;
    mem_ack     = 1'b0;
    mem_rdata   = 8'h00;
  endtask

  // One complete fetch. 'noise' drives fetch_start/pc_load/mem_ack junk
  // during REQ/DONE, all of which must be ignored.
  task automatic do_fetch(input bit load, input logic [7:0] din, input int waits,
                          input logic [7:0] rdata, input bit noise);
    exp_t e;
    int   req_cycles;
    logic [7:0] pc_before;
    fetch_start = 1'b1;
    pc_load     = load;
    pc_din      = din;
    if (load) m_pc = din;
    e.addr = m_pc;
    e.ir   = rdata;
    e.pc   = m_pc + 8'd1;
    sb.push_back(e);
    step();
    pc_before  = m_pc;
    m_pc       = e.pc;
    m_ir       = rdata;
    req_cycles = 0;
    for (int i = 0; i <= waits; i++) begin
      if (noise) begin
        fetch_start = 1'($urandom);
        pc_load     = 1'($urandom);
        pc_din      = 8'($urandom);
      end else begin
        fetch_start = 1'b0;
        pc_load     = 1'b0;
      end
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? rdata : 8'($urandom);
      if (mem_req === 1'b1) req_cycles++;
      check("req_addr_stable", mem_addr, e.addr);
      check("req_pc_hold", pc, pc_before);
      check("req_no_valid", ir_valid, 1'b0);
      step();
    end
    check("req_cycles", req_cycles, waits + 1);
    // DONE cycle
    check("done_valid", ir_valid, 1'b1);
    check("done_mem_req", mem_req, 1'b0);
    check("done_busy", fetch_busy, 1'b1);
    if (noise) begin
      fetch_start = 1'b1;
      pc_load     = 1'b1;
      pc_din      = 8'($urandom);
      mem_ack     = 1'b1;
      mem_rdata   = ~rdata;
    end else begin
      idle_inputs();
    end
    step();
    idle_inputs();
    // back in IDLE: nothing relaunched, state as modelled
    check("idle_busy", fetch_busy, 1'b0);
    check("idle_mem_req", mem_req, 1'b0);
    check("idle_pc", pc, m_pc);
    check("idle_ir", ir, m_ir);
    step();
    check("idle2_mem_req", mem_req, 1'b0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    idle_inputs();
    reset = 1'b0;
    m_pc  = 8'h00;
    m_ir  = 8'h00;
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_ir", ir, 8'h00);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_ir_valid", ir_valid, 1'b0);
    check("rst_busy", fetch_busy, 1'b0);
    check("rst_err", fetch_err, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();

    // First fetch after reset: addr 0, ir 0x34, pc 1, ir_valid at +2.
    do_fetch(1'b0, 8'h00, 0, 8'h34, 1'b0);
    check("first_instr", instr, 4'h4);
    check("first_pc", pc, 8'h01);

    // pc load in IDLE without a fetch.
    pc_load = 1'b1;
    pc_din  = 8'h5A;
    m_pc    = 8'h5A;
    step();
    idle_inputs();
    check("idle_load_pc", pc, 8'h5A);
    check("idle_load_no_req", mem_req, 1'b0);

    // Reach pc=0xFF, then fetch with 3 wait cycles: wraps to 0x00.
    do_fetch(1'b1, 8'hFE, 1, 8'hA7, 1'b0);
    check("pre_wrap_pc", pc, 8'hFF);
    do_fetch(1'b0, 8'h00, 3, 8'hC2, 1'b0);
    check("wrap_pc", pc, 8'h00);

    // Branch target and fetch_start together: fetch from 0x80.
    do_fetch(1'b1, 8'h80, 0, 8'h19, 1'b0);
    check("branch_pc", pc, 8'h81);

    // Junk on control inputs during REQ/DONE must be ignored.
    do_fetch(1'b0, 8'h00, 2, 8'h6E, 1'b1);
    check("noise_pc", pc, 8'h82);

    // Reset in the middle of REQ, then a stray acknowledge.
    fetch_start = 1'b1;
    sb.push_back('{addr: m_pc, ir: 8'h00, pc: 8'h00});
    step();
    fetch_start = 1'b0;
    check("pre_rst_mem_req", mem_req, 1'b1);
    step();
    #2;
    reset = 1'b0;
    #1;
    void'(sb.pop_back());
    m_pc = 8'h00;
    m_ir = 8'h00;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_ir", ir, 8'h00);
    check("midrst_pc", pc, 8'h00);
    check("midrst_busy", fetch_busy, 1'b0);
    step();
    reset = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 8'h55;
    step();
    idle_inputs();
    step();
    check("post_rst_ir", ir, 8'h00);
    check("post_rst_pc", pc, 8'h00);
    check("post_rst_mem_req", mem_req, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    // Never acknowledge: abort after TB_LIMIT REQ cycles, pc untouched.
    begin
      int cyc;
      do_fetch(1'b1, 8'h40, 0, 8'h27, 1'b0);
      sb.push_back('{addr: m_pc, ir: 8'h01, pc: m_pc});
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      cyc = 0;
      while (mem_req === 1'b1 && cyc < 100) begin
        cyc++;
        step();
      end
      check("to_req_cycles", cyc, TB_LIMIT);
      check("to_ir", ir, 8'h01);
      check("to_err", fetch_err, 1'b1);
      check("to_pc", pc, m_pc);
      m_ir = 8'h01;
      step();
      do_fetch(1'b0, 8'h00, 1, 8'h3C, 1'b0);
      check("to_err_sticky", fetch_err, 1'b1);
    end
`else
    check("no_to_err", fetch_err, 1'b0);
`endif

    // Randomized fetches against the model.
    for (int n = 0; n < 40; n++) begin
      do_fetch(1'($urandom), 8'($urandom), int'($urandom_range(0, 5)),
               8'($urandom), 1'($urandom));
    end

    step();
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_LIMIT, default 15, giving the number of REQ cycles without an acknowledge before a fetch aborts.
REQ-002 The block SHALL have port clock, input, 1, the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset; asserted when 0.
REQ-004 The block SHALL have port fetch_start, input, 1, pulse from the control FSM requesting an instruction fetch at the current PC.
REQ-005 The block SHALL have port pc_load, input, 1, load the PC from pc_din (taken branch).
REQ-006 The block SHALL have port pc_din, input, 8, branch target from the ALU.
REQ-007 The block SHALL have port mem_req, output, 1, memory read request, held until acknowledged.
REQ-008 The block SHALL have port mem_addr, output, 8, read address, stable while mem_req=1.
REQ-009 The block SHALL have port mem_ack, input, 1, one-cycle acknowledge qualifying mem_rdata.
REQ-010 The block SHALL have port mem_rdata, input, 8, instruction word.
REQ-011 The block SHALL have port ir, output, 8, instruction register.
REQ-012 The block SHALL have port instr, output, 4, ir[3:0], the opcode field consumed by the FSM.
REQ-013 The block SHALL have port pc, output, 8, program counter.
REQ-014 The block SHALL have port ir_valid, output, 1, one-cycle pulse when ir holds a newly fetched word.
REQ-015 The block SHALL have port fetch_busy, output, 1, high whenever state is not IDLE; the FSM stalls on it.
REQ-016 The block SHALL have port fetch_err, output, 1, sticky fetch-timeout flag.

Function
REQ-017 The state machine SHALL have states IDLE, REQ and DONE.
REQ-018 IDLE SHALL go to REQ on fetch_start=1 and SHALL otherwise hold.
REQ-019 REQ SHALL go to DONE on mem_ack=1.
REQ-020 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-021 On entry to REQ, mem_addr SHALL register pc_din if pc_load=1 in the same cycle, and pc otherwise.
REQ-022 mem_req SHALL equal 1 exactly while in REQ; latency from fetch_start to mem_req SHALL be 1 cycle.
REQ-023 On mem_ack in REQ, ir SHALL load mem_rdata and pc SHALL load mem_addr+1, with 8-bit wrap (0xFF -> 0x00).
REQ-024 ir_valid SHALL be high exactly during DONE; minimum fetch_start-to-ir_valid latency SHALL be 2 cycles (ack in the first REQ cycle).
REQ-025 In IDLE, pc_load=1 SHALL set pc to pc_din on that edge; pc_load takes priority over a simultaneous fetch_start for the address used.
REQ-026 pc_load in REQ or DONE SHALL be ignored; pc and ir SHALL be unchanged.
REQ-027 fetch_start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-028 mem_ack outside REQ SHALL be ignored.
REQ-029 ir and pc SHALL change only as stated in REQ-023, REQ-025 and REQ-033.

Reset
REQ-030 On reset=0, asynchronously: state=IDLE, pc=0x00, ir=0x00, mem_addr=0x00, mem_req=0, ir_valid=0, fetch_busy=0, fetch_err=0, timeout counter=0.
REQ-031 Reset during REQ SHALL drop mem_req immediately; a later mem_ack SHALL NOT load ir.

Configuration
REQ-032 The block SHALL use macro FETCH_TIMEOUT_EN to compile the fetch timeout in or out.
REQ-033 With FETCH_TIMEOUT_EN defined: a counter SHALL clear on REQ entry and increment each REQ cycle without ack; when it reaches TIMEOUT_LIMIT, the next state SHALL be DONE, ir SHALL load 0x01 (stop opcode), pc SHALL be unchanged, and fetch_err SHALL set and stay set until reset.
REQ-034 Without FETCH_TIMEOUT_EN: REQ SHALL wait indefinitely, fetch_err SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-035 Package fetch_pkg SHALL hold the state encoding (IDLE=0, REQ=1, DONE=2, 2 bits), OPC_STOP=4'h1, and the default TIMEOUT_LIMIT.
REQ-036 Sub-module fetch_timeout_ctr (the counter with a terminal-count output) SHALL be instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-037 After reset release, pulse fetch_start with mem_ack returned in the first REQ cycle and mem_rdata=0x34 -> mem_addr=0x00, ir=0x34, instr=4, pc=0x01, ir_valid at cycle +2.
REQ-038 With pc=0xFF, fetch with ack after 3 wait cycles -> mem_req high for 4 cycles, pc=0x00 afterward.
REQ-039 In IDLE, assert pc_load=1 with pc_din=0x80 and fetch_start in the same cycle -> mem_addr=0x80, pc=0x81 after the ack.
REQ-040 Assert fetch_start, pc_load and mem_ack during REQ/DONE -> no second fetch, no PC change, at most one ir load.
REQ-041 Assert reset=0 mid-REQ, then mem_ack -> mem_req=0 immediately, ir=0x00, pc=0x00.
REQ-042 With FETCH_TIMEOUT_EN defined, never ack -> after 15 REQ cycles ir=0x01, fetch_err=1 sticky, pc unchanged.
